// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the unified processor memory: the CPU wins by priority,
// the loader is forced through after STARVE_MAX consecutive losses.
module mem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  localparam logic [2:0] STARVE_LIM = 3'(STARVE_MAX);
  localparam logic [2:0] LAT_INIT   = 3'(MEM_LAT);

  state_t            state_reg;
  logic [2:0]        starve_cnt_reg;
  logic [2:0]        lat_cnt_reg;
  logic              owner_reg;      // 0 = CPU, 1 = loader
  logic              cpu_gnt_reg;
  logic              ld_gnt_reg;
  logic              cpu_rvalid_reg;
  logic              ld_rvalid_reg;
  logic              mem_en_reg;
  logic              mem_we_reg;
  logic [ADDR_W-1:0] mem_addr_reg;
  logic [DATA_W-1:0] mem_wdata_reg;

  logic ld_wins;
  logic capture;

  assign ld_wins = ld_req && (!cpu_req || (starve_cnt_reg == STARVE_LIM));
  assign capture = (state_reg == S_WAIT) && (lat_cnt_reg == 3'd1);

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_reg      <= S_IDLE;
      starve_cnt_reg <= '0;
      lat_cnt_reg    <= '0;
      owner_reg      <= 1'b0;
      cpu_gnt_reg    <= 1'b0;
      ld_gnt_reg     <= 1'b0;
      cpu_rvalid_reg <= 1'b0;
      ld_rvalid_reg  <= 1'b0;
      mem_en_reg     <= 1'b0;
      mem_we_reg     <= 1'b0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
    end else begin
      cpu_gnt_reg    <= 1'b0;
      ld_gnt_reg     <= 1'b0;
      cpu_rvalid_reg <= 1'b0;
      ld_rvalid_reg  <= 1'b0;
      mem_en_reg     <= 1'b0;
      mem_we_reg     <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (cpu_req || ld_req) begin
            // Winner's fields go straight into the memory-side registers for ISSUE
            owner_reg  <= ld_wins;
            mem_en_reg <= 1'b1;
            state_reg  <= S_ISSUE;
            if (ld_wins) begin
              ld_gnt_reg     <= 1'b1;
              mem_we_reg     <= ld_we;
              mem_addr_reg   <= ld_addr;
              mem_wdata_reg  <= ld_wdata;
              starve_cnt_reg <= '0;
            end else begin
              cpu_gnt_reg    <= 1'b1;
              mem_we_reg     <= cpu_we;
              mem_addr_reg   <= cpu_addr;
              mem_wdata_reg  <= cpu_wdata;
              if (!ld_req)
                starve_cnt_reg <= '0;
              else if (starve_cnt_reg != STARVE_LIM)
                starve_cnt_reg <= starve_cnt_reg + 3'd1;
            end
          end else begin
            starve_cnt_reg <= '0;
          end
        end
        S_ISSUE: begin
          if (mem_we_reg) begin
            state_reg <= S_IDLE;
          end else begin
            state_reg   <= S_WAIT;
            lat_cnt_reg <= LAT_INIT;
          end
        end
        S_WAIT: begin
          lat_cnt_reg <= lat_cnt_reg - 3'd1;
          if (capture) begin
            cpu_rvalid_reg <= !owner_reg;
            ld_rvalid_reg  <= owner_reg;
            state_reg      <= S_IDLE;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

  // One read-data holding register per requester; only the owner's is written
  for (genvar gi = 0; gi < 2; gi++) begin : g_rdata
    logic [DATA_W-1:0] rdata_reg;
    always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset)
        rdata_reg <= '0;
      else if (capture && (owner_reg == 1'(gi)))
        rdata_reg <= mem_rdata;
    end
  end

  assign cpu_rdata  = g_rdata[0].rdata_reg;
  assign ld_rdata   = g_rdata[1].rdata_reg;
  assign cpu_gnt    = cpu_gnt_reg;
  assign ld_gnt     = ld_gnt_reg;
  assign cpu_rvalid = cpu_rvalid_reg;
  assign ld_rvalid  = ld_rvalid_reg;
  assign mem_en     = mem_en_reg;
  assign mem_we     = mem_we_reg;
  assign mem_addr   = mem_addr_reg;
  assign mem_wdata  = mem_wdata_reg;
  assign busy       = (state_reg != S_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: per-scenario tasks, expected read data and
// grant order queued at stimulus time and popped when the DUT responds.
module tb_mem_arbiter;
  localparam int LAT  = 2;
  localparam int SMAX = 4;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        cpu_req, cpu_we, ld_req, ld_we;
  logic [15:0] cpu_addr, cpu_wdata, ld_addr, ld_wdata;
  logic        cpu_gnt, cpu_rvalid, ld_gnt, ld_rvalid;
  logic [15:0] cpu_rdata, ld_rdata;
  logic        mem_en, mem_we, busy;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;
  logic [15:0] cpu_q[$];
  logic [15:0] ld_q[$];
  bit          gnt_q[$];

  always #5 CLK = ~CLK;

  mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (
    .CLK(CLK), .Reset(Reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  // Memory model: write on mem_en&mem_we, read data appears LAT cycles after the strobe
  logic [15:0] mem [0:1023];
  logic [15:0] rd_pipe [0:LAT-1];
  bit          mem_init = 1'b0;
  always @(posedge CLK) begin
    if (!Reset && !mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= (i == 16'h40) ? 16'hBEEF : (16'(i) ^ 16'h5A5A);
      mem_init <= 1'b1;
    end else if (mem_en && mem_we) begin
      mem[mem_addr[9:0]] <= mem_wdata;
    end
    rd_pipe[0] <= mem[mem_addr[9:0]];
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[LAT-1];

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    Reset = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    ld_req = 0; ld_we = 0; ld_addr = '0; ld_wdata = '0;
    repeat (3) tick();
    checks++;
    if ({cpu_gnt, ld_gnt, cpu_rvalid, ld_rvalid, mem_en, mem_we, busy} !== 7'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 0000000",
               {cpu_gnt, ld_gnt, cpu_rvalid, ld_rvalid, mem_en, mem_we, busy});
    end
    checks++;
    if ({mem_addr, mem_wdata} !== 32'h0) begin
      errors++;
      $display("FAIL reset_mem: got addr %h wdata %h expected 0", mem_addr, mem_wdata);
    end
    checks++;
    if ({cpu_rdata, ld_rdata} !== 32'h0) begin
      errors++;
      $display("FAIL reset_rdata: got cpu %h ld %h expected 0", cpu_rdata, ld_rdata);
    end
    Reset = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b0 || mem_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got busy %b mem_en %b expected 0", busy, mem_en);
    end
    $display("reset: done");
  endtask

  task automatic test_cpu_read;
    int seen = -1;
    int pulses = 0;
    logic [15:0] exp;
    cpu_q.push_back(16'hBEEF);
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0040;
    tick();
    checks++;
    if ({cpu_gnt, ld_gnt, mem_en, mem_we, busy} !== 5'b10101 || mem_addr !== 16'h0040) begin
      errors++;
      $display("FAIL cpu_read_issue: got gnt %b lgnt %b en %b we %b busy %b addr %h expected 1 0 1 0 1 0040",
               cpu_gnt, ld_gnt, mem_en, mem_we, busy, mem_addr);
    end
    cpu_req = 0;
    for (int c = 2; c <= 10; c++) begin
      tick();
      if (cpu_rvalid) begin
        pulses++;
        if (seen < 0) begin
          seen = c;
          exp = cpu_q.pop_front();
          checks++;
          if (cpu_rdata !== exp) begin
            errors++;
            $display("FAIL cpu_read_data: got %h expected %h", cpu_rdata, exp);
          end
        end
      end
    end
    checks++;
    if (seen != 2 + LAT || pulses != 1) begin
      errors++;
      $display("FAIL cpu_read_latency: got cycle %0d pulses %0d expected cycle %0d pulses 1", seen, pulses, 2 + LAT);
    end
    checks++;
    if (ld_rdata !== 16'h0) begin
      errors++;
      $display("FAIL cpu_read_ld_rdata: got %h expected 0000", ld_rdata);
    end
    $display("cpu_read: addr 0040 rvalid cycle %0d data %h", seen, cpu_rdata);
  endtask

  task automatic test_ld_write;
    int rv = 0;
    int seen = -1;
    logic [15:0] exp;
    ld_req = 1; ld_we = 1; ld_addr = 16'h0100; ld_wdata = 16'h1234;
    tick();
    checks++;
    if ({ld_gnt, cpu_gnt, mem_en, mem_we} !== 4'b1011 || mem_wdata !== 16'h1234 || mem_addr !== 16'h0100) begin
      errors++;
      $display("FAIL ld_write_issue: got lgnt %b cgnt %b en %b we %b addr %h wdata %h expected 1 0 1 1 0100 1234",
               ld_gnt, cpu_gnt, mem_en, mem_we, mem_addr, mem_wdata);
    end
    ld_req = 0;
    tick();
    checks++;
    if (busy !== 1'b0 || mem_en !== 1'b0) begin
      errors++;
      $display("FAIL ld_write_idle: got busy %b mem_en %b expected 0 0", busy, mem_en);
    end
    for (int c = 0; c < 5; c++) begin
      if (ld_rvalid) rv++;
      tick();
    end
    checks++;
    if (rv != 0) begin
      errors++;
      $display("FAIL ld_write_rvalid: got %0d pulses expected 0", rv);
    end
    // Read it back through the loader port
    ld_q.push_back(16'h1234);
    ld_req = 1; ld_we = 0; ld_addr = 16'h0100;
    tick();
    ld_req = 0;
    for (int c = 2; c <= 10; c++) begin
      tick();
      if (ld_rvalid && seen < 0) begin
        seen = c;
        exp = ld_q.pop_front();
        checks++;
        if (ld_rdata !== exp) begin
          errors++;
          $display("FAIL ld_readback: got %h expected %h", ld_rdata, exp);
        end
      end
    end
    checks++;
    if (seen != 2 + LAT || cpu_rdata !== 16'hBEEF) begin
      errors++;
      $display("FAIL ld_readback_timing: got cycle %0d cpu_rdata %h expected cycle %0d cpu_rdata beef",
               seen, cpu_rdata, 2 + LAT);
    end
    $display("ld_write: addr 0100 wdata 1234 readback %h", ld_rdata);
  endtask

  task automatic test_reset_mid_read;
    int rv = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0044;
    tick();
    cpu_req = 0;
    tick();
    Reset = 1'b0;
    #1;
    checks++;
    if ({cpu_gnt, ld_gnt, cpu_rvalid, ld_rvalid, mem_en, mem_we, busy} !== 7'b0 ||
        {mem_addr, mem_wdata, cpu_rdata, ld_rdata} !== 64'h0) begin
      errors++;
      $display("FAIL reset_mid_read: got busy %b addr %h cpu_rdata %h ld_rdata %h expected all 0",
               busy, mem_addr, cpu_rdata, ld_rdata);
    end
    tick();
    Reset = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (cpu_rvalid || busy) rv++;
    end
    checks++;
    if (rv != 0) begin
      errors++;
      $display("FAIL reset_mid_read_after: got %0d rvalid/busy cycles expected 0", rv);
    end
    $display("reset_mid_read: transaction abandoned");
  endtask

  task automatic test_starvation;
    bit exp;
    int n = 0;
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < SMAX; k++) gnt_q.push_back(1'b0);
      gnt_q.push_back(1'b1);
    end
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0200; cpu_wdata = 16'h1111;
    ld_req = 1; ld_we = 1; ld_addr = 16'h0201; ld_wdata = 16'h2222;
    for (int c = 0; c < 60 && gnt_q.size() > 0; c++) begin
      tick();
      if (cpu_gnt || ld_gnt) begin
        exp = gnt_q.pop_front();
        n++;
        checks++;
        if (ld_gnt !== exp || cpu_gnt !== !exp) begin
          errors++;
          $display("FAIL starve_order: grant %0d got cpu %b ld %b expected ld %b", n, cpu_gnt, ld_gnt, exp);
        end
        if (ld_gnt) begin
          checks++;
          if (dut.starve_cnt_reg !== 3'd0) begin
            errors++;
            $display("FAIL starve_clear: got %0d expected 0", dut.starve_cnt_reg);
          end
        end
        $display("starvation: grant %0d to %s", n, ld_gnt ? "L" : "C");
      end
    end
    cpu_req = 0; ld_req = 0;
    checks++;
    if (gnt_q.size() != 0) begin
      errors++;
      $display("FAIL starve_timeout: got %0d grants expected %0d", n, 2 * (SMAX + 1));
    end
    gnt_q.delete();
    repeat (2) tick();
  endtask

  task automatic test_arrival_busy;
    int cv = -1, lg = -1, lv = -1;
    logic [15:0] exp;
    cpu_q.push_back(16'hBEEF);
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0040;
    tick();
    cpu_req = 0;
    tick();
    ld_q.push_back(16'h1234);
    ld_req = 1; ld_we = 0; ld_addr = 16'h0100;
    for (int c = 2; c < 25; c++) begin
      if (cpu_rvalid && cv < 0) begin
        cv = c;
        exp = cpu_q.pop_front();
        checks++;
        if (cpu_rdata !== exp) begin
          errors++;
          $display("FAIL arrival_cpu_data: got %h expected %h", cpu_rdata, exp);
        end
      end
      if (ld_gnt && lg < 0) begin
        lg = c;
        ld_req = 0;
      end
      if (ld_rvalid && lv < 0) begin
        lv = c;
        exp = ld_q.pop_front();
        checks++;
        if (ld_rdata !== exp) begin
          errors++;
          $display("FAIL arrival_ld_data: got %h expected %h", ld_rdata, exp);
        end
      end
      tick();
    end
    ld_req = 0;
    checks++;
    if (cv != 2 + LAT || lg != 3 + LAT || lv != 4 + 2 * LAT) begin
      errors++;
      $display("FAIL arrival_timing: got rvalid %0d ld_gnt %0d ld_rvalid %0d expected %0d %0d %0d",
               cv, lg, lv, 2 + LAT, 3 + LAT, 4 + 2 * LAT);
    end
    $display("arrival_busy: cpu_rvalid %0d ld_gnt %0d ld_rvalid %0d", cv, lg, lv);
  endtask

  task automatic test_dropped;
    int lg = 0, en = 0, cv = -1;
    logic [15:0] exp;
    cpu_q.push_back(16'hBEEF);
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0040;
    tick();
    cpu_req = 0;
    tick();
    ld_req = 1; ld_we = 1; ld_addr = 16'h03FF; ld_wdata = 16'hDEAD;
    tick();
    ld_req = 0;
    for (int c = 3; c < 14; c++) begin
      if (ld_gnt) lg++;
      if (mem_en) en++;
      if (cpu_rvalid && cv < 0) begin
        cv = c;
        exp = cpu_q.pop_front();
        checks++;
        if (cpu_rdata !== exp) begin
          errors++;
          $display("FAIL dropped_cpu_data: got %h expected %h", cpu_rdata, exp);
        end
      end
      tick();
    end
    checks++;
    if (lg != 0 || en != 0 || cv != 2 + LAT) begin
      errors++;
      $display("FAIL dropped_req: got ld_gnt %0d mem_en %0d rvalid %0d expected 0 0 %0d", lg, en, cv, 2 + LAT);
    end
    $display("dropped: ld_gnt %0d mem_en %0d", lg, en);
  endtask

  task automatic test_back_to_back;
    int g[3];
    int n = 0, rv = 0;
    logic [15:0] exp;
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h0300; cpu_wdata = 16'hA5A5;
    for (int c = 1; c < 20 && n < 3; c++) begin
      tick();
      if (cpu_gnt) begin
        g[n] = c; n++;
        if (n == 3) cpu_req = 0;
      end
    end
    cpu_req = 0;
    checks++;
    if (n != 3 || g[1] - g[0] != 2 || g[2] - g[1] != 2) begin
      errors++;
      $display("FAIL b2b_write_spacing: got %0d grants at %0d %0d %0d expected spacing 2", n, g[0], g[1], g[2]);
    end
    $display("back_to_back: writes granted at %0d %0d %0d", g[0], g[1], g[2]);
    repeat (2) tick();
    n = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0300;
    for (int c = 1; c < 40; c++) begin
      tick();
      checks++;
      if (cpu_gnt && cpu_rvalid) begin
        errors++;
        $display("FAIL b2b_overlap: got gnt and rvalid together at cycle %0d expected never", c);
      end
      if (cpu_gnt && n < 3) begin
        g[n] = c; n++;
        cpu_q.push_back(16'hA5A5);
        if (n == 3) cpu_req = 0;
      end
      if (cpu_rvalid) begin
        rv++;
        exp = (cpu_q.size() > 0) ? cpu_q.pop_front() : 16'hXXXX;
        checks++;
        if (cpu_rdata !== exp) begin
          errors++;
          $display("FAIL b2b_read_data: got %h expected %h", cpu_rdata, exp);
        end
      end
    end
    cpu_req = 0;
    checks++;
    if (n != 3 || rv != 3 || g[1] - g[0] != LAT + 2 || g[2] - g[1] != LAT + 2 || ld_rdata !== 16'h1234) begin
      errors++;
      $display("FAIL b2b_read_spacing: got %0d grants %0d rvalids at %0d %0d %0d ld_rdata %h expected spacing %0d ld_rdata 1234",
               n, rv, g[0], g[1], g[2], ld_rdata, LAT + 2);
    end
    $display("back_to_back: reads granted at %0d %0d %0d", g[0], g[1], g[2]);
  endtask

  initial begin
    test_reset();
    test_cpu_read();
    test_ld_write();
    test_reset_mid_read();
    test_starvation();
    test_arrival_busy();
    test_dropped();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
